// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative Div/Mult sequencer, the HI/LO mux and the main control unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_EXC   = 3'd4
    } state_e;

    localparam logic HILO_SEL_MULT = 1'b0;
    localparam logic HILO_SEL_DIV  = 1'b1;

    localparam int DIV_CYCLES_DEF  = 32;
    localparam int MULT_CYCLES_DEF = 32;
    localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Command/status bundle between the main control unit (master) and the Div/Mult sequencer (slave).
interface muldiv_seq_ctrl_if;
    import muldiv_pkg::*;

    // Handshake: start_div/start_mult are one-cycle requests that are taken only while the
    // sequencer is in IDLE; at any other time they are dropped, not queued. busy stalls the
    // master from LOAD through RUN; completion is the single done/hilo_we pulse, or a
    // div_zero_exc pulse when a division by zero was refused.
    logic        start_div;
    logic        start_mult;
    logic [31:0] divisor;
    logic        div_resetlocal;
    logic        mult_resetlocal;
    logic        busy;
    logic        hilo_we;
    logic        hilo_sel;
    logic        div_zero_exc;
    logic        done;
    state_e      state;

    modport master (
        output start_div, start_mult, divisor,
        input  div_resetlocal, mult_resetlocal, busy, hilo_we, hilo_sel,
               div_zero_exc, done, state
    );

    modport slave (
        input  start_div, start_mult, divisor,
        output div_resetlocal, mult_resetlocal, busy, hilo_we, hilo_sel,
               div_zero_exc, done, state
    );

endinterface

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter for the iteration phase; last_o flags the final iteration (count == 1).
module muldiv_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturates at zero so an enable with nothing loaded can never wrap.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative Div/Mult units: load pulse, iteration count, single HI/LO write.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_seq_ctrl_if.slave    bus
);

    state_e           state_q;
    state_e           state_d;
    logic             sel_q;
    logic             sel_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_en;
    logic             cnt_last;

    muldiv_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .last_o     (cnt_last)
    );

    // Division has priority over multiplication when both starts arrive together.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_div) begin
                    if (bus.divisor == 32'd0) begin
                        state_d = ST_EXC;
                    end else begin
                        state_d  = ST_LOAD;
                        sel_d    = HILO_SEL_DIV;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(DIV_CYCLES);
                    end
                end else if (bus.start_mult) begin
                    state_d  = ST_LOAD;
                    sel_d    = HILO_SEL_MULT;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(MULT_CYCLES);
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_EXC: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= HILO_SEL_MULT;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Every output is a decode of registered state, so start_* never reaches an output combinationally.
    assign bus.div_resetlocal  = (state_q == ST_LOAD) && (sel_q == HILO_SEL_DIV);
    assign bus.mult_resetlocal = (state_q == ST_LOAD) && (sel_q == HILO_SEL_MULT);
    assign bus.busy            = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign bus.hilo_we         = (state_q == ST_WRITE);
    assign bus.done            = (state_q == ST_WRITE);
    assign bus.div_zero_exc    = (state_q == ST_EXC);
    assign bus.hilo_sel        = sel_q;
    assign bus.state           = state_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: vector table, hand-written corner sequences, random traffic.
module tb_muldiv_seq_ctrl;
    import muldiv_pkg::*;

    localparam int N_DIV  = 32;
    localparam int N_MULT = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_ctrl_if ifc ();

    muldiv_seq_ctrl #(
        .DIV_CYCLES  (N_DIV),
        .MULT_CYCLES (N_MULT),
        .CNT_W       (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // Timeline view: each accepted command is a start edge plus a kind; outputs for any
    // cycle follow arithmetically from the latency rules (LOAD at e, WRITE at e+N+1).
    int   cyc      = 0;
    bit   m_valid  = 0;
    bit   m_active = 0;
    int   m_kind   = 0;   // 0 mult, 1 div, 2 divide-by-zero
    int   m_e      = 0;
    int   m_n      = 0;
    int   m_free   = 0;   // first cycle in which the sequencer is idle again
    logic m_sel    = 1'b0;

    // ---------------- observation ----------------
    int   txn_cyc, obs_div_rl, obs_mult_rl, obs_busy, obs_we, obs_exc;
    int   obs_we_cyc, obs_exc_cyc;
    logic obs_sel_we;
    logic [6:0] last_act;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [6:0] model_out(input int d);
        logic drl, mrl, b, we, ex;
        drl = 1'b0; mrl = 1'b0; b = 1'b0; we = 1'b0; ex = 1'b0;
        if (m_active) begin
            if (m_kind == 2) begin
                ex = (d == m_e);
            end else begin
                drl = (d == m_e) && (m_kind == 1);
                mrl = (d == m_e) && (m_kind == 0);
                b   = (d >= m_e) && (d <= m_e + m_n);
                we  = (d == m_e + m_n + 1);
            end
        end
        return {drl, mrl, b, we, m_sel, ex, we};
    endfunction

    task automatic model_edge(input logic r, input logic sd, input logic sm, input logic [31:0] dv);
        if (r) begin
            m_valid  = 1;
            m_active = 0;
            m_sel    = HILO_SEL_MULT;
            m_free   = cyc;
        end else if (m_valid && (cyc - 1 >= m_free)) begin
            if (sd && dv == 32'd0) begin
                m_active = 1; m_kind = 2; m_e = cyc; m_free = cyc + 1;
            end else if (sd) begin
                m_active = 1; m_kind = 1; m_e = cyc; m_n = N_DIV;
                m_sel = HILO_SEL_DIV; m_free = cyc + N_DIV + 2;
            end else if (sm) begin
                m_active = 1; m_kind = 0; m_e = cyc; m_n = N_MULT;
                m_sel = HILO_SEL_MULT; m_free = cyc + N_MULT + 2;
            end
        end
    endtask

    task automatic clear_obs();
        txn_cyc = 0; obs_div_rl = 0; obs_mult_rl = 0; obs_busy = 0; obs_we = 0; obs_exc = 0;
        obs_we_cyc = 0; obs_exc_cyc = 0; obs_sel_we = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Inputs driven here are sampled at the next rising edge; outputs checked on the falling edge.
    task automatic step(input logic r, input logic sd, input logic sm, input logic [31:0] dv);
        logic [6:0] act, exp;
        reset          = r;
        ifc.start_div  = sd;
        ifc.start_mult = sm;
        ifc.divisor    = dv;
        @(posedge clk);
        cyc++;
        model_edge(r, sd, sm, dv);
        @(negedge clk);
        txn_cyc++;
        act = {ifc.div_resetlocal, ifc.mult_resetlocal, ifc.busy, ifc.hilo_we,
               ifc.hilo_sel, ifc.div_zero_exc, ifc.done};
        last_act = act;
        if (m_valid) begin
            exp = model_out(cyc);
            n_checks++;
            if (act == exp) n_pass++;
            else $display("FAIL outputs cycle %0d: got %b expected %b (div_rl mult_rl busy we sel exc done)",
                          cyc, act, exp);
        end
        if (act[6]) obs_div_rl++;
        if (act[5]) obs_mult_rl++;
        if (act[4]) obs_busy++;
        if (act[3]) begin
            obs_we++;
            if (obs_we_cyc == 0) begin
                obs_we_cyc = txn_cyc;
                obs_sel_we = act[2];
            end
        end
        if (act[1]) begin
            obs_exc++;
            if (obs_exc_cyc == 0) obs_exc_cyc = txn_cyc;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        sd;
        logic        sm;
        logic [31:0] dv;
        int          e_div_rl;
        int          e_mult_rl;
        int          e_busy;
        int          e_we;
        int          e_we_cyc;
        int          e_sel;
        int          e_exc;
        int          e_exc_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"div_7",      1'b1, 1'b0, 32'd7, 1, 0, 33, 1, 34, 1, 0, 0};
        vecs[1] = '{"mult",       1'b0, 1'b1, 32'd9, 0, 1, 33, 1, 34, 0, 0, 0};
        vecs[2] = '{"div_zero",   1'b1, 1'b0, 32'd0, 0, 0,  0, 0,  0, 0, 1, 1};
        vecs[3] = '{"both_div3",  1'b1, 1'b1, 32'd3, 1, 0, 33, 1, 34, 1, 0, 0};
        vecs[4] = '{"both_zero",  1'b1, 1'b1, 32'd0, 0, 0,  0, 0,  0, 0, 1, 1};
        vecs[5] = '{"mult_again", 1'b0, 1'b1, 32'd0, 0, 1, 33, 1, 34, 0, 0, 0};

        ifc.start_div  = 1'b0;
        ifc.start_mult = 1'b0;
        ifc.divisor    = 32'd0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'd5);
        check("reset_outputs", int'(last_act), 0);
        idle_steps(2);

        for (int v = 0; v < 6; v++) begin
            clear_obs();
            step(1'b0, vecs[v].sd, vecs[v].sm, vecs[v].dv);
            idle_steps(39);
            check({vecs[v].name, "_div_rl"},  obs_div_rl,  vecs[v].e_div_rl);
            check({vecs[v].name, "_mult_rl"}, obs_mult_rl, vecs[v].e_mult_rl);
            check({vecs[v].name, "_busy"},    obs_busy,    vecs[v].e_busy);
            check({vecs[v].name, "_we"},      obs_we,      vecs[v].e_we);
            check({vecs[v].name, "_we_cyc"},  obs_we_cyc,  vecs[v].e_we_cyc);
            check({vecs[v].name, "_exc"},     obs_exc,     vecs[v].e_exc);
            check({vecs[v].name, "_exc_cyc"}, obs_exc_cyc, vecs[v].e_exc_cyc);
            if (vecs[v].e_we > 0) check({vecs[v].name, "_sel"}, int'(obs_sel_we), vecs[v].e_sel);
        end

        // Divide-by-zero leaves the sequencer idle at cycle 2: a multiply started there is taken.
        clear_obs();
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'd0);
        idle_steps(37);
        check("exc_then_mult_exc", obs_exc, 1);
        check("exc_then_mult_rl", obs_mult_rl, 1);
        check("exc_then_mult_we_cyc", obs_we_cyc, 36);

        // start_mult pulsed during RUN (cycle 5) and WRITE (cycle 34) of a division is dropped.
        clear_obs();
        step(1'b0, 1'b1, 1'b0, 32'd100);
        for (int j = 2; j <= 40; j++) step(1'b0, 1'b0, (j == 6) || (j == 35), 32'd0);
        check("repulse_we", obs_we, 1);
        check("repulse_mult_rl", obs_mult_rl, 0);
        check("repulse_we_cyc", obs_we_cyc, 34);
        check("repulse_sel", int'(obs_sel_we), 1);

        // Reset at cycle 10 of a division aborts it; a fresh division then runs normally.
        clear_obs();
        step(1'b0, 1'b1, 1'b0, 32'd100);
        idle_steps(9);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("midreset_outputs", int'(last_act), 0);
        idle_steps(30);
        check("midreset_no_we", obs_we, 0);
        clear_obs();
        step(1'b0, 1'b1, 1'b0, 32'd13);
        idle_steps(39);
        check("after_reset_we_cyc", obs_we_cyc, 34);
        check("after_reset_div_rl", obs_div_rl, 1);

        // Random traffic against the timeline model
        for (int i = 0; i < 1500; i++) begin
            logic r, sd, sm;
            logic [31:0] dv;
            r  = ($urandom_range(0, 199) == 0);
            sd = ($urandom_range(0, 14) == 0);
            sm = ($urandom_range(0, 14) == 0);
            dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step(r, sd, sm, dv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Sequencer for the iterative multi-cycle arithmetic units (Div and Mult).
- Accepts a start command from the main control unit and pulses the unit-local reset so the selected unit loads its operands.
- Counts the iteration cycles, then issues a single HI/LO write enable.
- Stalls the main control unit while busy and raises a divide-by-zero exception instead of running a division by zero.

Parameters:
- DIV_CYCLES, 32, iteration cycles the Div unit needs after its load cycle.
- MULT_CYCLES, 32, iteration cycles the Mult unit needs after its load cycle.
- CNT_W, 6, counter width; must hold max(DIV_CYCLES, MULT_CYCLES).

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high global reset.
- start_div  in  1  one-cycle request to start a division; sampled only in IDLE.
- start_mult  in  1  one-cycle request to start a multiplication; sampled only in IDLE.
- divisor  in  32  divisor operand, used only for the zero check at start.
- div_resetlocal  out  1  drives Div resetlocal; high for exactly the LOAD cycle of a division.
- mult_resetlocal  out  1  drives Mult resetlocal; high for exactly the LOAD cycle of a multiplication.
- busy  out  1  stall request to the main control unit.
- hilo_we  out  1  one-cycle write enable for the HI/LO registers.
- hilo_sel  out  1  HI/LO source mux select: 0 = Mult, 1 = Div; held from LOAD through WRITE.
- div_zero_exc  out  1  one-cycle divide-by-zero exception pulse.
- done  out  1  one-cycle completion pulse, coincident with hilo_we.

Behaviour:
- Reset (synchronous, from any state, including mid-operation):
  - state = IDLE, counter = 0, hilo_sel = 0.
  - All other outputs are 0.
  - The arithmetic units are not pulsed by this block on reset; the global reset already clears them.
- States: IDLE, LOAD, RUN, WRITE, EXC. Outputs are registered or decoded from state only; no combinational path from start_* to any output.
- IDLE:
  - start_div=1 and divisor==0 -> EXC.
  - start_div=1 and divisor!=0 -> LOAD, hilo_sel=1, counter=DIV_CYCLES.
  - else start_mult=1 -> LOAD, hilo_sel=0, counter=MULT_CYCLES.
  - If both starts are asserted, division wins and start_mult is dropped.
- LOAD:
  - Assert the resetlocal matching hilo_sel and busy=1.
  - The unit captures its operands at the end of this cycle.
  - Next state: RUN.
- RUN:
  - busy=1; counter decrements each cycle.
  - When counter==1 in this cycle -> WRITE, so RUN lasts exactly the configured cycle count.
- WRITE:
  - hilo_we=1, done=1, busy=0.
  - Next state: IDLE.
  - start_* asserted during WRITE is ignored.
- EXC:
  - div_zero_exc=1, busy=0, hilo_we=0; no resetlocal pulse. HI/LO is left unmodified.
  - Next state: IDLE.
- Latency: start sampled at edge E0; LOAD occupies cycle E0–E1; hilo_we is high in the cycle after edge E(1+N), where N = DIV_CYCLES or MULT_CYCLES. For the defaults, 34 cycles from start to write.
- Divide-by-zero: exception pulse in the cycle after the start edge (latency 1).
- start_* asserted in LOAD, RUN, WRITE or EXC is ignored: no queuing, no error.
- divisor is compared only at the start edge; later changes have no effect.
- The counter never wraps: it is loaded only on the IDLE->LOAD transition and held at 0 outside RUN.

Decomposition:
- Shared package muldiv_pkg:
  - state encoding constants (IDLE=0, LOAD=1, RUN=2, WRITE=3, EXC=4, 3-bit);
  - HILO_SEL_MULT=0 and HILO_SEL_DIV=1;
  - default cycle-count constants, reused by the HI/LO mux and the main control unit.
- One natural sub-module: muldiv_cycle_counter, a loadable down-counter with load, enable and a last flag (count==1).
- The FSM stays in muldiv_seq_ctrl.

Test Plan:
- Reset, then start_div=1 with divisor=7 (Div fed 100/7) -> div_resetlocal high for exactly 1 cycle; busy high 33 cycles; hilo_we=done=1 in cycle 34 with hilo_sel=1; Div outputs Lo=14, Hi=2 on that cycle.
- start_mult=1 (Mult fed 6×9) -> mult_resetlocal 1 cycle; hilo_we in cycle 34 with hilo_sel=0; product 54 presented.
- start_div=1 with divisor=0 -> div_zero_exc=1 at cycle 1 only; no resetlocal, no hilo_we, busy never high; back in IDLE at cycle 2.
- start_div and start_mult asserted together (divisor=3) -> only div_resetlocal pulses; hilo_sel=1; exactly one hilo_we.
- start_mult re-pulsed at cycles 5 and 34 of a running division -> ignored: exactly one hilo_we; next command accepted only in IDLE.
- Assert reset at cycle 10 of a division -> next cycle busy=0 and all outputs 0; no hilo_we occurs; a new start_div then completes with the normal 34-cycle latency.
